// File: rtl/sp3_uplink_pkg.sv
// sp3_uplink_pkg: shared widths, capture FSM encoding and frame-to-word packing.
// Rev 1.0
`default_nettype none
package sp3_uplink_pkg;
  localparam int UPLINK_W        = 234;
  localparam int FRAME_W         = UPLINK_W + 1;
  localparam int WORDS_PER_FRAME = 8;
  localparam int RD_W            = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_READOUT   = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

  // The last word carries the FEC flag and the 10 frame bits above the 7 full words.
  function automatic logic [RD_W-1:0] pack_word(input logic [UPLINK_W-1:0] frame,
                                                input logic                fec,
                                                input logic [2:0]          k);
    logic [7:0]          base;
    logic [UPLINK_W-1:0] sh;
    base = {k, 5'd0};
    sh   = frame >> base;
    if (k == 3'(WORDS_PER_FRAME - 1)) begin
      return {fec, 21'd0, frame[UPLINK_W-1:224]};
    end
    return sh[RD_W-1:0];
  endfunction
endpackage
`default_nettype wire

// File: rtl/sp3_uplink_capture_if.sv
// sp3_uplink_capture_if: 32-bit valid/ready readout stream toward the readout FIFO.
// Rev 1.0
`default_nettype none
interface sp3_uplink_capture_if;
  import sp3_uplink_pkg::*;

  logic [RD_W-1:0] rd_data;
  logic            rd_valid;
  logic            rd_last;
  logic            rd_ready;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);
endinterface
`default_nettype wire

// File: rtl/sp3_frame_ram.sv
// sp3_frame_ram: simple dual-port frame buffer, registered write and registered read.
// Rev 1.0
`default_nettype none
module sp3_frame_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 235,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/sp3_uplink_capture.sv
// sp3_uplink_capture: arms, waits for a masked frame trigger, buffers frames and
// serializes them as 8 x 32-bit words per frame. Rev 1.0
`default_nettype none
module sp3_uplink_capture
  import sp3_uplink_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16,
  localparam int CL_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk20,
  input  logic                 rst,
  input  logic                 uplinkrdy,
  input  logic                 uplinkFEC,
  input  logic [UPLINK_W-1:0]  uplinkUserData,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig_en,
  input  logic [31:0]          trig_mask,
  input  logic [31:0]          trig_value,
  input  logic [CL_W-1:0]      cap_len,
  sp3_uplink_capture_if.master rd,
  output logic [2:0]           state_o,
  output logic                 done_o,
  output logic [CL_W-1:0]      frames_o,
  output logic [CNT_W-1:0]     fec_cnt_o,
  output logic [CNT_W-1:0]     loss_cnt_o
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CL_W-1:0] FULL_LEN = CL_W'(DEPTH);

  cap_state_t          state_q;
  logic                trig_en_q;
  logic [31:0]         mask_q;
  logic [31:0]         value_q;
  logic [CL_W-1:0]     len_q;
  logic [CL_W-1:0]     frames_q;
  logic [CNT_W-1:0]    fec_q;
  logic [CNT_W-1:0]    loss_q;
  logic                done_q;
  logic                rdy_q;
  logic                rd_valid_q;
  logic [1:0]          fetch_q;
  logic [2:0]          word_q;
  logic [AW-1:0]       rd_frame_q;
  logic [UPLINK_W-1:0] sh_data_q;
  logic                sh_fec_q;

  logic [CL_W-1:0]     len_clamped;
  logic                trig_hit;
  logic                wr_en;
  logic                xfer;
  logic                last_word;
  logic                link_drop;
  logic [AW-1:0]       ram_raddr;
  logic [FRAME_W-1:0]  ram_rdata;

  assign len_clamped = (cap_len == '0 || cap_len > FULL_LEN) ? FULL_LEN : cap_len;
  assign trig_hit    = !trig_en_q || (((uplinkUserData[31:0] ^ value_q) & mask_q) == 32'd0);
  assign wr_en       = !abort && uplinkrdy &&
                       ((state_q == ST_WAIT_TRIG && trig_hit) || state_q == ST_CAPTURE);
  assign xfer        = rd_valid_q && rd.rd_ready;
  assign last_word   = (word_q == 3'(WORDS_PER_FRAME - 1));
  assign link_drop   = rdy_q && !uplinkrdy &&
                       (state_q inside {ST_WAIT_TRIG, ST_CAPTURE, ST_READOUT});
  // Prefetch the next frame on the last handshake so only one bubble separates frames.
  assign ram_raddr   = (xfer && last_word) ? rd_frame_q + AW'(1) : rd_frame_q;

  sp3_frame_ram #(.DEPTH(DEPTH), .WIDTH(FRAME_W)) u_ram (
    .clk     (clk20),
    .we_i    (wr_en),
    .waddr_i (frames_q[AW-1:0]),
    .wdata_i ({uplinkFEC, uplinkUserData}),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk20 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      trig_en_q  <= 1'b0;
      mask_q     <= '0;
      value_q    <= '0;
      len_q      <= '0;
      frames_q   <= '0;
      fec_q      <= '0;
      loss_q     <= '0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      fetch_q    <= 2'd0;
      word_q     <= 3'd0;
      rd_frame_q <= '0;
      sh_data_q  <= '0;
      sh_fec_q   <= 1'b0;
    end else begin
      rdy_q <= uplinkrdy;
      if (link_drop && loss_q != '1) begin
        loss_q <= loss_q + CNT_W'(1);
      end
      if (wr_en) begin
        frames_q <= frames_q + CL_W'(1);
        if (uplinkFEC && fec_q != '1) begin
          fec_q <= fec_q + CNT_W'(1);
        end
      end
      if (abort) begin
        state_q    <= ST_IDLE;
        rd_valid_q <= 1'b0;
        done_q     <= 1'b0;
        fetch_q    <= 2'd0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              state_q    <= ST_WAIT_TRIG;
              trig_en_q  <= trig_en;
              mask_q     <= trig_mask;
              value_q    <= trig_value;
              len_q      <= len_clamped;
              frames_q   <= '0;
              fec_q      <= '0;
              loss_q     <= '0;
              done_q     <= 1'b0;
              rd_frame_q <= '0;
            end
          end
          ST_WAIT_TRIG, ST_CAPTURE: begin
            if (wr_en && frames_q + CL_W'(1) == len_q) begin
              state_q <= ST_READOUT;
              fetch_q <= 2'd2;
            end else if (wr_en && state_q == ST_WAIT_TRIG) begin
              state_q <= ST_CAPTURE;
            end
          end
          ST_READOUT: begin
            if (fetch_q == 2'd2) begin
              fetch_q <= 2'd1;
            end else if (fetch_q == 2'd1) begin
              fetch_q                <= 2'd0;
              {sh_fec_q, sh_data_q}  <= ram_rdata;
              word_q                 <= 3'd0;
              rd_valid_q             <= 1'b1;
            end else if (xfer) begin
              if (!last_word) begin
                word_q <= word_q + 3'd1;
              end else begin
                rd_valid_q <= 1'b0;
                if ({1'b0, rd_frame_q} + CL_W'(1) == frames_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else begin
                  rd_frame_q <= ram_raddr;
                  fetch_q    <= 2'd1;
                end
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_valid_q && last_word;
  assign rd.rd_data  = pack_word(sh_data_q, sh_fec_q, word_q);

  assign state_o    = state_q;
  assign done_o     = done_q;
  assign frames_o   = frames_q;
  assign fec_cnt_o  = fec_q;
  assign loss_cnt_o = loss_q;
endmodule
`default_nettype wire

// File: tb/tb_sp3_uplink_capture.sv
// tb_sp3_uplink_capture: randomized capture runs checked against a queue-based frame model.
// Rev 1.0
`default_nettype none
module tb_sp3_uplink_capture;
  localparam int DEPTH = 16;
  localparam int CNT_W = 3;
  localparam int CL_W  = 5;
  localparam int SAT   = 7;
  localparam int M_RAND = 0, M_INC = 1, M_BYTE = 2, M_GAP2 = 3, M_TOGGLE = 4;

  logic             clk20 = 1'b0;
  logic             rst;
  logic             uplinkrdy;
  logic             uplinkFEC;
  logic [233:0]     uplinkUserData;
  logic             arm;
  logic             abort;
  logic             trig_en;
  logic [31:0]      trig_mask;
  logic [31:0]      trig_value;
  logic [CL_W-1:0]  cap_len;
  logic [2:0]       state_o;
  logic             done_o;
  logic [CL_W-1:0]  frames_o;
  logic [CNT_W-1:0] fec_cnt_o;
  logic [CNT_W-1:0] loss_cnt_o;

  sp3_uplink_capture_if rd_if();

  sp3_uplink_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk20          (clk20),
    .rst            (rst),
    .uplinkrdy      (uplinkrdy),
    .uplinkFEC      (uplinkFEC),
    .uplinkUserData (uplinkUserData),
    .arm            (arm),
    .abort          (abort),
    .trig_en        (trig_en),
    .trig_mask      (trig_mask),
    .trig_value     (trig_value),
    .cap_len        (cap_len),
    .rd             (rd_if),
    .state_o        (state_o),
    .done_o         (done_o),
    .frames_o       (frames_o),
    .fec_cnt_o      (fec_cnt_o),
    .loss_cnt_o     (loss_cnt_o)
  );

  always #5 clk20 = ~clk20;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk20);
    #1;
  endtask

  function automatic int sat(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  function automatic logic [233:0] rnd_frame();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[233:0];
  endfunction

  task automatic check_zero_outputs();
    chk("zero_state", state_o, 0);
    chk("zero_done", done_o, 0);
    chk("zero_frames", frames_o, 0);
    chk("zero_fec", fec_cnt_o, 0);
    chk("zero_loss", loss_cnt_o, 0);
    chk("zero_valid", rd_if.rd_valid, 0);
    chk("zero_last", rd_if.rd_last, 0);
    chk("zero_data", rd_if.rd_data, 0);
  endtask

  // One arm-capture-readout run; abort_at / rst_at (>= 0) cut the run short.
  task automatic run_capture(input bit ten, input logic [31:0] msk, input logic [31:0] val,
                             input int len_in, input int mode, input int gap_pct,
                             input int fec_pct, input int rdy_pct,
                             input int abort_at, input int rst_at);
    int           exp_len, nstored, fec_n, loss_n, cyc, wi, last_first;
    bit           prev_rdy, trig_seen, r, f, hold_p, seen_valid;
    logic [233:0] d;
    logic [31:0]  hold_d, w;
    logic [31:0]  expw[$];
    logic [233:0] st_data[$];
    bit           st_fec[$];

    exp_len   = (len_in == 0 || len_in > DEPTH) ? DEPTH : len_in;
    trig_en   = ten;
    trig_mask = msk;
    trig_value = val;
    cap_len   = CL_W'(len_in);
    uplinkrdy = 1'b1;
    uplinkFEC = 1'b0;
    rd_if.rd_ready = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("armed_state", state_o, 1);

    nstored = 0; fec_n = 0; loss_n = 0; prev_rdy = 1'b1; trig_seen = 1'b0;
    for (int i = 0; i < 3000 && nstored < exp_len; i++) begin
      chk("frames_run", frames_o, nstored);
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1 check_zero_outputs();
        tick();
        rst = 1'b0;
        tick();
        return;
      end
      r = 1'b1;
      d = rnd_frame();
      case (mode)
        M_INC:    d = 234'(nstored + 1);
        M_BYTE:   begin d[7:0] = 8'(i); r = ($urandom_range(99) >= gap_pct); end
        M_GAP2:   r = !(i == 3 || i == 6);
        M_TOGGLE: r = (i % 2 == 0);
        default:  r = ($urandom_range(99) >= gap_pct);
      endcase
      f = (mode == M_GAP2) ? (nstored == 2) : ($urandom_range(99) < fec_pct);
      uplinkrdy = r;
      uplinkFEC = f;
      uplinkUserData = d;
      if (prev_rdy && !r) loss_n++;
      prev_rdy = r;
      if (r && (trig_seen || !ten || ((d[31:0] & msk) == (val & msk)))) begin
        trig_seen = 1'b1;
        st_data.push_back(d);
        st_fec.push_back(f);
        nstored++;
        if (f) fec_n++;
      end
      tick();
    end
    uplinkrdy = 1'b1;
    uplinkFEC = 1'b0;
    if (nstored < exp_len) begin
      chk("capture_timeout", nstored, exp_len);
      return;
    end

    foreach (st_data[j]) begin
      for (int k = 0; k < 7; k++) expw.push_back(st_data[j][k*32 +: 32]);
      expw.push_back({st_fec[j], 21'd0, st_data[j][233:224]});
    end

    chk("enter_readout", state_o, 3);
    cyc = 0; wi = 0; hold_p = 1'b0; seen_valid = 1'b0; last_first = 0;
    while (expw.size() > 0 && cyc < 4000) begin
      if (hold_p) begin
        chk("hold_valid", rd_if.rd_valid, 1);
        chk("hold_data", rd_if.rd_data, hold_d);
      end
      if (rd_if.rd_valid && !seen_valid) begin
        seen_valid = 1'b1;
        chk("valid_latency", cyc, 2);
      end
      if (cyc == abort_at) begin
        abort = 1'b1;
        rd_if.rd_ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_valid", rd_if.rd_valid, 0);
        chk("abort_state", state_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_frames", frames_o, exp_len);
        chk("abort_fec", fec_cnt_o, sat(fec_n));
        chk("abort_loss", loss_cnt_o, sat(loss_n));
        return;
      end
      rd_if.rd_ready = ($urandom_range(99) < rdy_pct);
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        w = expw.pop_front();
        chk("rd_data", rd_if.rd_data, w);
        chk("rd_last", rd_if.rd_last, (wi % 8) == 7);
        if (wi % 8 == 0) begin
          if (rdy_pct == 100 && wi > 0) chk("frame_period", cyc - last_first, 9);
          last_first = cyc;
        end
        wi++;
      end
      hold_p = rd_if.rd_valid && !rd_if.rd_ready;
      hold_d = rd_if.rd_data;
      tick();
      cyc++;
    end
    rd_if.rd_ready = 1'b0;
    if (expw.size() > 0) chk("readout_timeout", expw.size(), 0);
    chk("done_flag", done_o, 1);
    chk("done_state", state_o, 4);
    chk("done_valid", rd_if.rd_valid, 0);
    chk("frames", frames_o, exp_len);
    chk("fec_cnt", fec_cnt_o, sat(fec_n));
    chk("loss_cnt", loss_cnt_o, sat(loss_n));
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_en = 1'b0;
    trig_mask = '0; trig_value = '0; cap_len = '0;
    uplinkrdy = 1'b0; uplinkFEC = 1'b0; uplinkUserData = '0;
    rd_if.rd_ready = 1'b0;
    repeat (3) @(posedge clk20);
    #1;
    check_zero_outputs();
    rst = 1'b0;
    tick();

    run_capture(1'b0, 32'h0,  32'h0,  4,  M_INC,    0,  0,   100, -1, -1);
    run_capture(1'b1, 32'hFF, 32'hA5, 8,  M_BYTE,   0,  0,   100, -1, -1);
    run_capture(1'b0, 32'h0,  32'h0,  6,  M_GAP2,   0,  0,   100, -1, -1);
    run_capture(1'b1, 32'h3,  32'h1,  5,  M_RAND,   20, 30,  50,  -1, -1);
    run_capture(1'b0, 32'h0,  32'h0,  0,  M_RAND,   10, 50,  70,  -1, -1);
    run_capture(1'b0, 32'h0,  32'h0,  17, M_RAND,   10, 50,  100, -1, -1);
    run_capture(1'b1, 32'hF0, 32'h50, 1,  M_RAND,   0,  50,  60,  -1, -1);
    run_capture(1'b0, 32'h0,  32'h0,  16, M_TOGGLE, 0,  100, 100, -1, -1);

    abort = 1'b1;
    arm   = 1'b1;
    tick();
    abort = 1'b0;
    arm   = 1'b0;
    chk("abort_arm_state", state_o, 0);
    chk("abort_arm_done", done_o, 0);
    chk("abort_arm_frames", frames_o, 16);
    tick();
    chk("abort_arm_idle", state_o, 0);

    run_capture(1'b0, 32'h0, 32'h0, 3, M_RAND, 0, 50, 100, 5, -1);
    tick();
    chk("post_abort_idle", state_o, 0);

    run_capture(1'b0, 32'h0, 32'h0, 8, M_RAND, 0, 50, 100, -1, 6);
    chk("post_reset_idle", state_o, 0);

    for (int n = 0; n < 4; n++) begin
      run_capture(1'($urandom_range(1)), 32'($urandom_range(15)), $urandom,
                  $urandom_range(20), M_RAND, 25, 40, 60, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
